uart_tx: RTL and testbench

UART transmitter: serialises one byte per valid/ready handshake into an 8N1 frame on a single TX line. It is the transmit-direction counterpart to the team's UART sampling receiver and runs from the same 25 MHz system clock. Bit timing comes from an internal clock-enable tick counter; no derived clocks are used, and every flop is clocked by clk_25mhz.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_tx.sv | 136 +++++++++++++
 tb/tb_uart_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud helper
package uart_pkg;

  // Transmit FSM states; PARITY is only reached when UART_TX_PARITY_EN is defined
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Mark level of an idle UART line
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Cycles per bit, rounded to nearest
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with restart and terminal-count tick
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  // Count 0..CLKS_PER_BIT-1, wrap at terminal count, hold at zero while restarted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_restart || (r_count == TERMINAL)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = (r_count == TERMINAL);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 25000000,
  parameter int BAUD         = 115200,
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic                 clk_25mhz,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be 5..8");
  end

  localparam int                 BIT_W    = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(DATA_BITS - 1);

  tx_state_t            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BIT_W-1:0]     r_bit;
  logic                 r_serial;
  logic                 r_done;
  logic                 w_tick;
  logic                 w_restart;
  logic                 w_accept;

  assign w_accept  = (r_state == IDLE) && tx_valid;
  // Counter sits at zero in IDLE so the start bit begins a full bit period
  assign w_restart = (r_state == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .i_clk    (clk_25mhz),
    .i_rst_n  (reset),
    .i_restart(w_restart),
    .o_tick   (w_tick)
  );

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  // Even parity of the accepted byte, captured alongside the shift register
  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^tx_data;
    end
  end
`endif

  // Frame sequencer; the line level for the next bit is registered on each transition
  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bit    <= '0;
      r_serial <= UART_IDLE_LEVEL;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_serial <= UART_IDLE_LEVEL;
          if (w_accept) begin
            r_shift  <= tx_data;
            r_bit    <= '0;
            r_serial <= 1'b0;
            r_state  <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_serial <= r_shift[0];
            r_state  <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_bit == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_serial <= r_parity;
              r_state  <= PARITY;
`else
              r_serial <= UART_IDLE_LEVEL;
              r_state  <= STOP;
`endif
            end else begin
              r_bit    <= r_bit + 1'b1;
              r_serial <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_serial <= UART_IDLE_LEVEL;
            r_state  <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            r_serial <= UART_IDLE_LEVEL;
            r_done   <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_serial <= UART_IDLE_LEVEL;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready  = (r_state == IDLE);
  assign tx_busy   = (r_state != IDLE);
  assign tx_serial = r_serial;
  assign tx_done   = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level line model
module tb_uart_tx;

  localparam int CLK_FREQ  = 25000000;
  localparam int BAUD      = 115200;
  localparam int DATA_BITS = 8;
  localparam int CPB       = (CLK_FREQ + BAUD / 2) / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DATA_BITS + 3;
`else
  localparam int NB = DATA_BITS + 2;
`endif
  localparam int FRAME_CYC = NB * CPB;

  logic       clk_25mhz = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  int n_checks   = 0;
  int n_pass     = 0;
  int cyc        = 0;
  int last_start = 0;

  uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DATA_BITS(DATA_BITS)
  ) dut (
    .clk_25mhz(clk_25mhz),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_serial(tx_serial),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  always @(posedge clk_25mhz) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected line bits of one frame, index 0 first on the wire
  function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
    logic [NB-1:0] f;
    f = '0;
    for (int i = 0; i < DATA_BITS; i++) f[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[DATA_BITS + 1] = ^d;
`endif
    f[NB - 1] = 1'b1;
    return f;
  endfunction

  task automatic idle_cycles(input int n, input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_25mhz);
      if (tx_serial !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) errs++;
    end
    check(tag, errs, 0);
  endtask

  // Called at a negedge with the DUT idle; acceptance happens at the next posedge
  task automatic run_frame(input logic [7:0] d, input bit hold, input logic [7:0] next_d,
                           input bit disturb);
    logic [NB-1:0] exp_f;
    logic [NB-1:0] rx;
    int line_err, hs_err, done_err;
    exp_f = frame_bits(d);
    rx = '0;
    line_err = 0;
    hs_err = 0;
    done_err = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    check($sformatf("accept_ready_%02h", d), tx_ready, 1);
    @(posedge clk_25mhz);
    for (int k = 1; k <= FRAME_CYC; k++) begin
      @(negedge clk_25mhz);
      if (tx_serial !== exp_f[(k - 1) / CPB]) line_err++;
      if (tx_ready !== 1'b0 || tx_busy !== 1'b1) hs_err++;
      if (tx_done !== 1'b0) done_err++;
      if ((k - 1) % CPB == CPB / 2) rx[(k - 1) / CPB] = tx_serial;
      if (k == 1) begin
        last_start = cyc;
        if (hold) tx_data = next_d;
        else tx_valid = 1'b0;
      end
      if (disturb && k == 3 * CPB) begin
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
      end
      if (disturb && k == 3 * CPB + 8) tx_valid = 1'b0;
    end
    check($sformatf("line_%02h", d), line_err, 0);
    check($sformatf("busy_ready_%02h", d), hs_err, 0);
    check($sformatf("no_early_done_%02h", d), done_err, 0);
    check($sformatf("rx_start_%02h", d), rx[0], 0);
    check($sformatf("rx_byte_%02h", d), rx[DATA_BITS:1], d);
    check($sformatf("rx_stop_%02h", d), rx[NB - 1], 1);
`ifdef UART_TX_PARITY_EN
    check($sformatf("rx_parity_%02h", d), rx[DATA_BITS + 1], ^d);
`endif
    // First IDLE cycle: done pulse, ready back, line high
    @(negedge clk_25mhz);
    check($sformatf("done_pulse_%02h", d), tx_done, 1);
    check($sformatf("ready_end_%02h", d), tx_ready, 1);
    check($sformatf("busy_end_%02h", d), tx_busy, 0);
    check($sformatf("line_end_%02h", d), tx_serial, 1);
  endtask

  task automatic abort_frame(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    tx_valid = 1'b0;
    repeat (4 * CPB + CPB / 2 - 1) @(negedge clk_25mhz);
    check("abort_busy_before", tx_busy, 1);
    check("abort_line_before", tx_serial, d[3]);
    #5 reset = 1'b0;
    #1;
    check("abort_line_async", tx_serial, 1);
    check("abort_busy_async", tx_busy, 0);
    check("abort_ready_async", tx_ready, 1);
    check("abort_done_async", tx_done, 0);
    repeat (3) @(negedge clk_25mhz);
    reset = 1'b1;
  endtask

  initial begin
    int s1;
    logic [7:0] rd;
    logic [7:0] rd2;

    #2 reset = 1'b0;
    #3;
    check("rst_serial", tx_serial, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    repeat (3) @(negedge clk_25mhz);
    reset = 1'b1;
    idle_cycles(1000, "idle_after_reset");

    run_frame(8'hA5, 1'b0, 8'h00, 1'b0);
    idle_cycles(50, "idle_after_a5");

    run_frame(8'h00, 1'b1, 8'hFF, 1'b0);
    s1 = last_start;
    run_frame(8'hFF, 1'b0, 8'h00, 1'b0);
    check("b2b_spacing", last_start - s1, FRAME_CYC + 1);
    idle_cycles(20, "idle_after_b2b");

    run_frame(8'hA5, 1'b0, 8'h00, 1'b1);
    idle_cycles(300, "no_extra_accept");

    abort_frame(8'hA5);
    idle_cycles(300, "idle_after_abort");
    run_frame(8'h5A, 1'b0, 8'h00, 1'b0);
    idle_cycles(10, "idle_after_5a");

    run_frame(8'h07, 1'b0, 8'h00, 1'b0);

    for (int r = 0; r < 3; r++) begin
      rd = 8'($urandom);
      idle_cycles($urandom_range(1, 20), "idle_random_gap");
      run_frame(rd, 1'b0, 8'h00, 1'b0);
    end

    rd  = 8'($urandom);
    rd2 = 8'($urandom);
    idle_cycles(5, "idle_before_rand_b2b");
    run_frame(rd, 1'b1, rd2, 1'b0);
    s1 = last_start;
    run_frame(rd2, 1'b0, 8'h00, 1'b0);
    check("rand_b2b_spacing", last_start - s1, FRAME_CYC + 1);
    idle_cycles(20, "idle_final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
